chip8_ram_arbiter: RTL and testbench
====================================

CHIP8_RAM_ARBITER -- requirements
Module: chip8_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: RAM address width in bits.
REQ-002 Parameter VID_MAX_WAIT, default 4: maximum number of cycles a pending video request waits while a CPU lock is active, range 1..15.
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_req / cpu_we / cpu_lock  input  1 each  CPU access request, write enable, hold-ownership hint.
REQ-006 cpu_addr  input  ADDR_W, cpu_wdata  input  8  CPU address and write data.
REQ-007 cpu_gnt  output  1, cpu_rvalid  output  1, cpu_rdata  output  8  CPU accept pulse, read-data strobe, read data.
REQ-008 vid_req  input  1, vid_addr  input  ADDR_W  video scanout read request (read-only requester).
REQ-009 vid_gnt  output  1, vid_rvalid  output  1, vid_rdata  output  8  video accept pulse, read-data strobe, read data.
REQ-010 ram_address_out  output  ADDR_W, ram_data_out  output  8, ram_write  output  1  registered single-port RAM command.
REQ-011 ram_data_in  input  8  RAM read data, valid during the cycle after the cycle in which ram_address_out holds the read address.

Function
REQ-012 The block SHALL evaluate requests every cycle N, register one winner's command at the end of N, and assert that winner's gnt for exactly one cycle, N+1.
REQ-013 Read data SHALL appear in cycle N+2: rvalid of the granted requester high for one cycle, rdata = ram_data_in combinationally.
REQ-014 Throughput SHALL be one access per cycle; a requester holding req after gnt is treated as a new request with the then-current addr, we and wdata.
REQ-015 A requester SHALL hold req, addr, we and wdata stable until gnt; the arbiter SHALL never grant a requester whose req is low.
REQ-016 FSM states: IDLE (no command issued), CPU (CPU command issued), VID (video command issued), CPU_LOCK (CPU command issued with cpu_lock high).
REQ-017 When only one requester is pending, it SHALL win.
REQ-018 When both are pending and the state is not CPU_LOCK, the requester not granted most recently SHALL win (round-robin).
REQ-019 In CPU_LOCK, a pending CPU request SHALL win over a pending video request until the video wait counter reaches VID_MAX_WAIT; the video request then wins.
REQ-020 The video wait counter SHALL increment each cycle vid_req is high without vid_gnt, clear on vid_gnt, and saturate at VID_MAX_WAIT.
REQ-021 CPU_LOCK SHALL be entered on a CPU grant with cpu_lock high, and exited on a CPU grant with cpu_lock low or on any cycle with cpu_req low.
REQ-022 With no requests pending, the FSM SHALL go to IDLE: ram_write = 0, ram_data_out = 0, ram_address_out holds its last value.
REQ-023 ram_write SHALL be high only in the cycle following a CPU write grant; video grants and CPU reads SHALL drive ram_write = 0.
REQ-024 Writes SHALL NOT produce rvalid.
REQ-025 Address arithmetic SHALL NOT be performed; addresses pass through unmodified at ADDR_W bits.

Reset
REQ-026 While reset is low: all gnt, rvalid and ram_write = 0; ram_address_out = 0; ram_data_out = 0; FSM = IDLE; wait counter = 0; last-granted = video, so the CPU wins the first tie.
REQ-027 Reset asserted mid-access SHALL cancel the access with no gnt or rvalid afterwards; any rdata in flight is discarded.

Configuration
REQ-028 CHIP8_ARB_PERF_EN defined: add output conflict_count [15:0], reset 0, incremented once per cycle in which both requests are pending, saturating at 0xFFFF.
REQ-029 CHIP8_ARB_PERF_EN undefined: no conflict_count port or logic; all other behaviour is identical.

Structure
REQ-030 Shared package chip8_pkg SHALL hold CHIP8_ADDR_W = 12, the arbiter state enum (IDLE, CPU, VID, CPU_LOCK) and the requester-id type (REQ_CPU, REQ_VID).
REQ-031 The design SHALL be a single module with no sub-modules.

Verification
REQ-032 CPU read only: cpu_req at 0x200 in cycle 0 -> cpu_gnt in cycle 1, ram_address_out = 0x200; RAM returns 0x6A -> cpu_rvalid and cpu_rdata = 0x6A in cycle 2.
REQ-033 CPU write: addr 0x300, wdata 0x55, we = 1 -> ram_write = 1 for one cycle with ram_address_out = 0x300 and ram_data_out = 0x55; no cpu_rvalid.
REQ-034 Both requests held continuously from reset, no lock -> grants alternate CPU, VID, CPU, VID.
REQ-035 cpu_lock held with both requests continuous, VID_MAX_WAIT = 4 -> 4 consecutive CPU grants, then vid_gnt, then CPU again.
REQ-036 Reset pulled low in the cycle after cpu_gnt for a read -> no cpu_rvalid; all outputs 0 the same cycle (asynchronous).
REQ-037 CHIP8_ARB_PERF_EN defined, both requests held for 10 cycles -> conflict_count = 10.

Source files
------------

// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared definitions for the CHIP-8 memory subsystem.
//   CHIP8_ADDR_W : default RAM address width (4 KiB address space)
//   arb_state_e  : RAM arbiter FSM state, named after the command issued
//                  in the current cycle
//   req_id_e     : identifies a RAM requester (CPU or video scanout)
// -----------------------------------------------------------------------------
package chip8_pkg;

  localparam int CHIP8_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // no command issued
    CPU      = 2'd1,  // CPU command issued
    VID      = 2'd2,  // video command issued
    CPU_LOCK = 2'd3   // CPU command issued with cpu_lock high
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_e;

endpackage : chip8_pkg

// File: rtl/chip8_ram_arbiter.sv
// -----------------------------------------------------------------------------
// chip8_ram_arbiter
// Shares one single-port RAM between the CPU (read/write) and the video
// scanout (read-only). Requests are evaluated every cycle N; the winner's RAM
// command is registered at the end of N, its gnt pulses in N+1 and, for a
// read, its rvalid pulses in N+2 with rdata taken straight from the RAM.
// Ties use round-robin, except while the CPU holds a lock: then the CPU keeps
// winning until the video request has waited VID_MAX_WAIT cycles.
//
// Parameters
//   ADDR_W        RAM address width
//   VID_MAX_WAIT  cycles a pending video request may wait under a CPU lock
//                 (1..15)
// Ports
//   clock, reset                       clock; asynchronous active-low reset
//   cpu_req/we/lock, cpu_addr/wdata    CPU request
//   cpu_gnt, cpu_rvalid, cpu_rdata     CPU accept pulse, read strobe, data
//   vid_req, vid_addr                  video read request
//   vid_gnt, vid_rvalid, vid_rdata     video accept pulse, read strobe, data
//   ram_address_out/data_out/write     registered RAM command
//   ram_data_in                        RAM read data (one cycle after address)
//   conflict_count                     cycles with both requests pending,
//                                      saturating; present only when
//                                      CHIP8_ARB_PERF_EN is defined
// -----------------------------------------------------------------------------
module chip8_ram_arbiter
  import chip8_pkg::*;
#(
  parameter int ADDR_W       = CHIP8_ADDR_W,
  parameter int VID_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [7:0]        vid_rdata,
  output logic [ADDR_W-1:0] ram_address_out,
  output logic [7:0]        ram_data_out,
  output logic              ram_write,
  input  logic [7:0]        ram_data_in
`ifdef CHIP8_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_count
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(VID_MAX_WAIT);

  arb_state_e        state_q, state_d;
  req_id_e           last_q, last_d;
  logic [3:0]        vid_wait_q, vid_wait_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              vid_gnt_q, vid_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              ram_write_q, ram_write_d;

  logic              cpu_win;
  logic              vid_win;

  // Winner selection for the current cycle.
  always_comb begin : arbitrate
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    cpu_win = 1'b0;
    vid_win = 1'b0;
    if (cpu_req && vid_req) begin
      if (state_q == CPU_LOCK) begin
        // The lock only delays video; once its wait saturates video wins.
        cpu_win = (vid_wait_q < WAIT_MAX);
      end else begin
        cpu_win = (last_q == REQ_VID);
      end
      vid_win = !cpu_win;
    end else begin
      cpu_win = cpu_req;
      vid_win = vid_req;
    end
  end

  always_comb begin : next_state
    state_d       = IDLE;
    last_d        = last_q;
    ram_address_d = ram_address_q;  // address holds when no command is issued
    ram_data_d    = 8'h00;
    ram_write_d   = 1'b0;
    cpu_gnt_d     = cpu_win;
    vid_gnt_d     = vid_win;
    // The RAM answers the command presented this cycle in the next one, so
    // the strobe follows the gnt by one cycle; CPU writes return nothing.
    cpu_rvalid_d  = cpu_gnt_q && !ram_write_q;
    vid_rvalid_d  = vid_gnt_q;

    if (cpu_win) begin
      state_d       = cpu_lock ? CPU_LOCK : CPU;
      last_d        = REQ_CPU;
      ram_address_d = cpu_addr;
      ram_write_d   = cpu_we;
      ram_data_d    = cpu_we ? cpu_wdata : 8'h00;
    end else if (vid_win) begin
      state_d       = VID;
      last_d        = REQ_VID;
      ram_address_d = vid_addr;
    end

    // Wait counter follows the visible vid_gnt pulse, not the decision.
    if (vid_gnt_q) begin
      vid_wait_d = 4'd0;
    end else if (vid_req && (vid_wait_q < WAIT_MAX)) begin
      vid_wait_d = vid_wait_q + 4'd1;
    end else begin
      vid_wait_d = vid_wait_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: an asynchronous reset clears every flop immediately, so an access
      // in flight is cancelled and no gnt/rvalid can appear afterwards.
      state_q       <= IDLE;
      last_q        <= REQ_VID;  // CPU wins the first tie
      vid_wait_q    <= 4'd0;
      cpu_gnt_q     <= 1'b0;
      vid_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= 8'h00;
      ram_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      vid_wait_q    <= vid_wait_d;
      cpu_gnt_q     <= cpu_gnt_d;
      vid_gnt_q     <= vid_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      vid_rvalid_q  <= vid_rvalid_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_write_q   <= ram_write_d;
    end
  end

  assign cpu_gnt         = cpu_gnt_q;
  assign vid_gnt         = vid_gnt_q;
  assign cpu_rvalid      = cpu_rvalid_q;
  assign vid_rvalid      = vid_rvalid_q;
  // Read data is forced to zero outside its strobe so nothing stale leaks out.
  assign cpu_rdata       = cpu_rvalid_q ? ram_data_in : 8'h00;
  assign vid_rdata       = vid_rvalid_q ? ram_data_in : 8'h00;
  assign ram_address_out = ram_address_q;
  assign ram_data_out    = ram_data_q;
  assign ram_write       = ram_write_q;

`ifdef CHIP8_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (cpu_req && vid_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_q <= 16'h0000;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule : chip8_ram_arbiter

// File: tb/tb_chip8_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_chip8_ram_arbiter
// Self-checking bench for chip8_ram_arbiter. A reference model turns each
// cycle's requests into expected gnt/RAM-command and rvalid/rdata records,
// queued with the cycle they are due; a monitor pops and compares them on the
// falling edge. A behavioural RAM answers the DUT. Random traffic is followed
// by directed scenarios (single read, write, round-robin, lock, reset abort,
// and the conflict counter when CHIP8_ARB_PERF_EN is defined).
// -----------------------------------------------------------------------------
module tb_chip8_ram_arbiter;

  localparam int ADDR_W       = 12;
  localparam int VID_MAX_WAIT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_lock;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_rvalid;
  logic [7:0]        vid_rdata;
  logic [ADDR_W-1:0] ram_address_out;
  logic [7:0]        ram_data_out;
  logic              ram_write;
  logic [7:0]        ram_data_in;
`ifdef CHIP8_ARB_PERF_EN
  logic [15:0]       conflict_count;
`endif

  chip8_ram_arbiter #(
    .ADDR_W      (ADDR_W),
    .VID_MAX_WAIT(VID_MAX_WAIT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_lock       (cpu_lock),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_gnt        (cpu_gnt),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_gnt        (vid_gnt),
    .vid_rvalid     (vid_rvalid),
    .vid_rdata      (vid_rdata),
    .ram_address_out(ram_address_out),
    .ram_data_out   (ram_data_out),
    .ram_write      (ram_write),
    .ram_data_in    (ram_data_in)
`ifdef CHIP8_ARB_PERF_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on contents of both the bench RAM and the model's memory copy.
  function automatic logic [7:0] init_byte(input logic [11:0] a);
    logic [3:0] hi;
    hi = a[11:8] + 4'd4;
    return a[7:0] ^ {hi, 4'hA};
  endfunction

  // ---------------- behavioural RAM ----------------
  logic [7:0] ram [4096];
  logic [7:0] ram_rd_q;
  assign ram_data_in = ram_rd_q;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_byte(12'(a));
      ram_rd_q <= 8'h00;
    end else begin
      if (ram_write) ram[ram_address_out] <= ram_data_out;
      ram_rd_q <= ram[ram_address_out];
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct {
    int                due;
    bit                cg;
    bit                vg;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } gnt_exp_t;

  typedef struct {
    int         due;
    bit         crv;
    bit         vrv;
    logic [7:0] data;
  } rd_exp_t;

  gnt_exp_t exp_g[$];
  rd_exp_t  exp_r[$];

  int                cyc = 0;
  bit                m_last_cpu;   // most recent grant went to the CPU
  bit                m_locked;     // last issued command was a locked CPU access
  int                m_wait;       // cycles the video request has waited
  bit                m_vid_prev;   // video was granted in the previous decision
  logic [ADDR_W-1:0] m_addr;       // address currently on the RAM port
  logic [7:0]        m_mem [4096];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_g.delete();
      exp_r.delete();
      m_last_cpu = 1'b0;
      m_locked   = 1'b0;
      m_wait     = 0;
      m_vid_prev = 1'b0;
      m_addr     = '0;
      for (int a = 0; a < 4096; a++) m_mem[a] = init_byte(12'(a));
    end else begin
      bit       cw, vw;
      gnt_exp_t g;
      rd_exp_t  r;
      cw = 1'b0;
      vw = 1'b0;
      if (cpu_req && !vid_req)      cw = 1'b1;
      else if (vid_req && !cpu_req) vw = 1'b1;
      else if (cpu_req && vid_req) begin
        if (m_locked) cw = (m_wait < VID_MAX_WAIT);
        else          cw = !m_last_cpu;
        vw = !cw;
      end
      // wait count seen by this decision came from earlier cycles
      if (m_vid_prev)   m_wait = 0;
      else if (vid_req) m_wait = (m_wait + 1 > VID_MAX_WAIT) ? VID_MAX_WAIT : m_wait + 1;
      m_vid_prev = vw;
      m_locked   = cw && cpu_lock;
      if (cw) m_last_cpu = 1'b1;
      if (vw) m_last_cpu = 1'b0;

      cyc = cyc + 1;
      g = '{due: cyc, cg: cw, vg: vw, wr: cw && cpu_we, addr: m_addr, data: 8'h00};
      r = '{due: cyc + 1, crv: 1'b0, vrv: 1'b0, data: 8'h00};
      if (cw) begin
        g.addr = cpu_addr;
        m_addr = cpu_addr;
        if (cpu_we) begin
          g.data = cpu_wdata;
          m_mem[cpu_addr] = cpu_wdata;
        end else begin
          r.crv  = 1'b1;
          r.data = m_mem[cpu_addr];
        end
      end else if (vw) begin
        g.addr = vid_addr;
        m_addr = vid_addr;
        r.vrv  = 1'b1;
        r.data = m_mem[vid_addr];
      end
      exp_g.push_back(g);
      exp_r.push_back(r);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (exp_g.size() > 0 && exp_g[0].due == cyc) begin
        gnt_exp_t g;
        g = exp_g.pop_front();
        check("cpu_gnt", 32'(cpu_gnt), 32'(g.cg));
        check("vid_gnt", 32'(vid_gnt), 32'(g.vg));
        check("ram_write", 32'(ram_write), 32'(g.wr));
        check("ram_address_out", 32'(ram_address_out), 32'(g.addr));
        check("ram_data_out", 32'(ram_data_out), 32'(g.data));
      end else begin
        check("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("idle_vid_gnt", 32'(vid_gnt), 32'd0);
        check("idle_ram_write", 32'(ram_write), 32'd0);
      end
      if (exp_r.size() > 0 && exp_r[0].due == cyc) begin
        rd_exp_t r;
        r = exp_r.pop_front();
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(r.crv));
        check("vid_rvalid", 32'(vid_rvalid), 32'(r.vrv));
        if (r.crv) check("cpu_rdata", 32'(cpu_rdata), 32'(r.data));
        if (r.vrv) check("vid_rdata", 32'(vid_rdata), 32'(r.data));
      end else begin
        check("idle_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("idle_vid_rvalid", 32'(vid_rvalid), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;
    check("reset_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("reset_vid_gnt", 32'(vid_gnt), 32'd0);
    check("reset_rvalid", 32'({cpu_rvalid, vid_rvalid}), 32'd0);
    check("reset_ram_write", 32'(ram_write), 32'd0);
    check("reset_ram_address_out", 32'(ram_address_out), 32'd0);
    check("reset_ram_data_out", 32'(ram_data_out), 32'd0);
    do_reset();

    // Random traffic; each requester keeps its request until it is granted.
    for (int i = 0; i < 3000; i++) begin
      if (cpu_gnt || !cpu_req) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = ($urandom_range(0, 2) == 0);
        cpu_lock  = ($urandom_range(0, 3) != 0);
        cpu_addr  = 12'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
      if (vid_gnt || !vid_req) begin
        vid_req  = ($urandom_range(0, 2) != 0);
        vid_addr = 12'($urandom_range(0, 31));
      end
      tick();
    end

    // Single CPU read of 0x200; RAM holds 0x6A there.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 12'h200;
    tick();
    check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("rd_ram_address_out", 32'(ram_address_out), 32'h200);
    cpu_req = 1'b0;
    tick();
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd_cpu_rdata", 32'(cpu_rdata), 32'h6A);
    tick();
    check("rd_cpu_rvalid_gone", 32'(cpu_rvalid), 32'd0);

    // CPU write 0x55 to 0x300.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h55;
    tick();
    check("wr_ram_write", 32'(ram_write), 32'd1);
    check("wr_ram_address_out", 32'(ram_address_out), 32'h300);
    check("wr_ram_data_out", 32'(ram_data_out), 32'h55);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("wr_ram_write_once", 32'(ram_write), 32'd0);
    check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);

    // Both requesting continuously, no lock: CPU, VID, CPU, VID ...
    do_reset();
    cpu_req = 1'b1; cpu_addr = 12'h010; vid_req = 1'b1; vid_addr = 12'h020;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_cpu_gnt", 32'(cpu_gnt), 32'((i % 2) == 0));
      check("rr_vid_gnt", 32'(vid_gnt), 32'((i % 2) == 1));
    end
    clear_inputs();
    tick();

    // Both continuous with lock held: four CPU grants, one VID, then CPU.
    do_reset();
    cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 12'h011; vid_req = 1'b1; vid_addr = 12'h021;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("lock_cpu_gnt", 32'(cpu_gnt), 32'(i != 4));
      check("lock_vid_gnt", 32'(vid_gnt), 32'(i == 4));
    end
    clear_inputs();
    tick();

    // Reset in the cycle after a read grant aborts the read.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 12'h123;
    tick();
    check("abort_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    reset   = 1'b0;
    #1;
    check("abort_gnt_cleared", 32'({cpu_gnt, vid_gnt}), 32'd0);
    check("abort_rvalid_cleared", 32'({cpu_rvalid, vid_rvalid}), 32'd0);
    check("abort_rdata_cleared", 32'({cpu_rdata, vid_rdata}), 32'd0);
    check("abort_ram_cleared", 32'({ram_write, ram_data_out, 4'h0, ram_address_out}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_rvalid", 32'(cpu_rvalid), 32'd0);
    end

`ifdef CHIP8_ARB_PERF_EN
    // Ten cycles with both requests pending.
    do_reset();
    check("perf_reset", 32'(conflict_count), 32'd0);
    cpu_req = 1'b1; cpu_addr = 12'h012; vid_req = 1'b1; vid_addr = 12'h022;
    repeat (10) tick();
    clear_inputs();
    check("perf_conflict_count", 32'(conflict_count), 32'd10);
    tick();
    check("perf_conflict_hold", 32'(conflict_count), 32'd10);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_chip8_ram_arbiter
